button_press_pulser: RTL and testbench
======================================

// Module: button_press_pulser
// PURPOSE
//  Consumes the 4-bit level, mutually-exclusive debounced buttons from the debouncer.
//  Produces per-button one-cycle press/release/long-press pulses and a held level for UI FSMs.
//  Sits between the debouncer and the tester command logic, in the same clock domain.
// PARAMETERS
//  FCLK       20000000  clock frequency in Hz; must be >= 1000
//  HOLD_MS    500       press duration (ms) for long press; must be >= 1
//  REPEAT_MS  100       auto-repeat period (ms); used only with the macro; must be >= 1
// PORTS
//  i_clk_mhz      in   1  system clock
//  i_rst_mhz      in   1  synchronous reset, active-high
//  i_btns_deb     in   4  debounced button levels; expected one-hot or zero
//  o_btn_pulse    out  4  one-cycle press pulse, one-hot; also the auto-repeat pulse
//  o_btn_release  out  4  one-cycle release pulse, one-hot
//  o_btn_long     out  4  one-cycle pulse when the long-press threshold is reached
//  o_btn_held     out  4  level; latched code while in ST_HOLD, else 0
// BEHAVIOUR
//  - All outputs are registered.
//  - Constants: c_hold = FCLK/1000*HOLD_MS and c_rep = FCLK/1000*REPEAT_MS, in clocks.
//  - State register s_code[3:0] latches the accepted button code.
//  - The timer is an integer; it clears on every state change and on every repeat pulse.
//  - Reset (synchronous): all outputs 0, s_code=0, timer=0, state=ST_WAIT_ZERO.
//    - Any pulse due in the reset cycle is dropped.
//    - A button held through reset never produces a press pulse.
//  - States:
//    ST_WAIT_ZERO
//      - Outputs 0.
//      - Go to ST_IDLE when i_btns_deb==0.
//    ST_IDLE
//      - If i_btns_deb is nonzero one-hot: s_code<=i_btns_deb, go to ST_PRESS.
//        o_btn_pulse=i_btns_deb on the next cycle (latency 1 clock from the input edge).
//      - A non-one-hot nonzero input is ignored; go to ST_WAIT_ZERO.
//    ST_PRESS
//      - If i_btns_deb != s_code: o_btn_release=s_code for 1 cycle.
//        Go to ST_IDLE if the input is 0, else ST_WAIT_ZERO.
//      - Else, when timer==c_hold-1: o_btn_long=s_code for 1 cycle, go to ST_HOLD.
//    ST_HOLD
//      - o_btn_held=s_code.
//      - If i_btns_deb != s_code: same release rule as ST_PRESS; o_btn_held=0 on the same cycle.
//  - Timing: press pulse at cycle P => o_btn_long at cycle P+c_hold, if still held.
//  - A release exactly at the long-press threshold cycle gives release only, no long pulse.
//  - Release has priority over the timer in every state.
//  - At most one of pulse/release/long is nonzero in any cycle.
//  - The pulse is suppressed for the release cycle.
//  - A code change A->B (no zero between) gives release of A and no press of B until the input returns to 0.
// CONFIGURATION
//  BUTTON_AUTO_REPEAT_EN defined:
//    - In ST_HOLD, o_btn_pulse=s_code for 1 cycle at P+c_hold+k*c_rep, k>=1, while held.
//    - The repeat timer is reset on ST_HOLD entry.
//  BUTTON_AUTO_REPEAT_EN undefined:
//    - No repeat pulses; REPEAT_MS is unused.
//    - Repeat-timer logic is not synthesized.
// TESTING  (FCLK=10000, HOLD_MS=50 -> c_hold=500; REPEAT_MS=10 -> c_rep=100)
//  1. Assert reset with 4'b0010 held, release reset, keep held 600 clks.
//     -> no pulse/long output.
//     Drop to 0, then press 4'b0010 -> o_btn_pulse=4'b0010 exactly 1 clk after input edge.
//  2. Press 4'b0100 for 200 clks, then 0.
//     -> 1 press pulse, then o_btn_release=4'b0100 for 1 clk.
//     -> o_btn_long and o_btn_held never assert.
//  3. Hold 4'b1000 for 750 clks.
//     -> o_btn_long=4'b1000 at P+500; o_btn_held=4'b1000 from P+501 until release.
//     -> With the macro: repeat pulses at P+600 and P+700. Without: none.
//  4. Switch 4'b0001 -> 4'b0010 directly.
//     -> release of 4'b0001; no press of 4'b0010 until the input is 0 then 4'b0010 again.
//  5. Apply input 4'b0110 in ST_IDLE -> all outputs stay 0.
//     Then 0 followed by 4'b0001 -> press pulse 4'b0001.
//  6. Assert reset at P+300 mid-press -> all outputs 0 the next clk.
//     After reset, while still held -> no long, no release.

Source files
------------

// File: rtl/button_press_pulser.sv
// Debounced one-hot button decoder: press/release/long-press pulses and a held level.
// Optional auto-repeat of the press pulse while held: define BUTTON_AUTO_REPEAT_EN.
module button_press_pulser #(
    parameter int unsigned FCLK      = 20000000,
    parameter int unsigned HOLD_MS   = 500,
    parameter int unsigned REPEAT_MS = 100
) (
    input  logic       i_clk_mhz,
    input  logic       i_rst_mhz,
    input  logic [3:0] i_btns_deb,
    output logic [3:0] o_btn_pulse,
    output logic [3:0] o_btn_release,
    output logic [3:0] o_btn_long,
    output logic [3:0] o_btn_held
);

    localparam int unsigned C_HOLD = FCLK / 1000 * HOLD_MS;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned C_REP = FCLK / 1000 * REPEAT_MS;
`endif

    if (FCLK < 1000) begin : g_chk_fclk
        $error("FCLK must be >= 1000");
    end
    if (HOLD_MS < 1) begin : g_chk_hold
        $error("HOLD_MS must be >= 1");
    end
    if (REPEAT_MS < 1) begin : g_chk_rep
        $error("REPEAT_MS must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_WAIT_ZERO,
        ST_IDLE,
        ST_PRESS,
        ST_HOLD
    } state_t;

    state_t      state;
    logic [3:0]  s_code;
    int unsigned timer;
    logic        in_onehot;
    logic        in_zero;
    logic        in_changed;

    always_comb begin
        in_zero    = (i_btns_deb == 4'd0);
        in_onehot  = !in_zero && ((i_btns_deb & (i_btns_deb - 4'd1)) == 4'd0);
        in_changed = (i_btns_deb != s_code);
    end

    always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
            state         <= ST_WAIT_ZERO;
            s_code        <= '0;
            timer         <= 0;
            o_btn_pulse   <= '0;
            o_btn_release <= '0;
            o_btn_long    <= '0;
            o_btn_held    <= '0;
        end else begin
            o_btn_pulse   <= '0;
            o_btn_release <= '0;
            o_btn_long    <= '0;
            o_btn_held    <= '0;
            case (state)
                ST_WAIT_ZERO: begin
                    if (in_zero) begin
                        state <= ST_IDLE;
                        timer <= 0;
                    end
                end
                ST_IDLE: begin
                    if (in_onehot) begin
                        s_code      <= i_btns_deb;
                        o_btn_pulse <= i_btns_deb;
                        state       <= ST_PRESS;
                        timer       <= 0;
                    end else if (!in_zero) begin
                        state <= ST_WAIT_ZERO;
                        timer <= 0;
                    end
                end
                ST_PRESS: begin
                    // Release is tested first so it wins over the long-press threshold.
                    if (in_changed) begin
                        o_btn_release <= s_code;
                        state         <= in_zero ? ST_IDLE : ST_WAIT_ZERO;
                        timer         <= 0;
                    end else if (timer == C_HOLD - 1) begin
                        o_btn_long <= s_code;
                        state      <= ST_HOLD;
                        timer      <= 0;
                    end else begin
                        timer <= timer + 1;
                    end
                end
                ST_HOLD: begin
                    if (in_changed) begin
                        o_btn_release <= s_code;
                        state         <= in_zero ? ST_IDLE : ST_WAIT_ZERO;
                        timer         <= 0;
                    end else begin
                        o_btn_held <= s_code;
`ifdef BUTTON_AUTO_REPEAT_EN
                        if (timer == C_REP - 1) begin
                            o_btn_pulse <= s_code;
                            timer       <= 0;
                        end else begin
                            timer <= timer + 1;
                        end
`endif
                    end
                end
                default: begin
                    state <= ST_WAIT_ZERO;
                    timer <= 0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_pulser.sv
// Scoreboard bench for button_press_pulser (c_hold=500, c_rep=100 clocks).
// Honours BUTTON_AUTO_REPEAT_EN the same way as the design.
module tb_button_press_pulser;

    typedef struct packed {
        int          cyc;
        logic [15:0] outs;   // {pulse, release, long, held}
    } ev_t;

    localparam ev_t NONE = '{cyc: -1, outs: 16'h0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btns = 4'd0;
    logic [3:0] pulse, rel, lng, held;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    logic [3:0] prev_held = 4'd0;

    button_press_pulser #(
        .FCLK(10000),
        .HOLD_MS(50),
        .REPEAT_MS(10)
    ) dut (
        .i_clk_mhz    (clk),
        .i_rst_mhz    (rst),
        .i_btns_deb   (btns),
        .o_btn_pulse  (pulse),
        .o_btn_release(rel),
        .o_btn_long   (lng),
        .o_btn_held   (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every cycle with a pulse of any kind or a change of the held level.
    always @(negedge clk) begin
        if ((pulse | rel | lng) != 4'd0 || held !== prev_held)
            obs_q.push_back('{cyc, {pulse, rel, lng, held}});
        prev_held = held;
    end

    task automatic drive(input logic [3:0] v, output int t);
        @(negedge clk);
        btns = v;
        t = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] l, input logic [3:0] h);
        exp_q.push_back('{c, {p, r, l, h}});
    endtask

    task automatic settle();
        int t;
        drive(4'd0, t);
        idle(3);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        int t, n;
        ev_t e, o;
        @(negedge clk);
        rst = 1'b1;
        btns = 4'b0010;
        idle(2);
        checks++;
        if ({pulse, rel, lng, held} !== 16'h0)
            $display("FAIL reset_outputs: got %h, expected 0000", {pulse, rel, lng, held});
        else passed++;
        exp_q.delete();
        obs_q.delete();
        rst = 1'b0;
        idle(600);
        drive(4'd0, t);
        idle(3);
        drive(4'b0010, t);
        push(t + 1, 4'b0010, 4'd0, 4'd0, 4'd0);
        idle(10);
        drive(4'd0, t);
        push(t + 1, 4'd0, 4'b0010, 4'd0, 4'd0);
        idle(5);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
            o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
            checks++;
            if (o !== e) $display("FAIL reset_hold ev%0d: got cyc=%0d outs=%h, expected cyc=%0d outs=%h", i, o.cyc, o.outs, e.cyc, e.outs);
            else passed++;
        end
    endtask

    task automatic test_short_press();
        int t, n;
        ev_t e, o;
        settle();
        drive(4'b0100, t);
        push(t + 1, 4'b0100, 4'd0, 4'd0, 4'd0);
        idle(199);
        drive(4'd0, t);
        push(t + 1, 4'd0, 4'b0100, 4'd0, 4'd0);
        idle(5);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
            o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
            checks++;
            if (o !== e) $display("FAIL short_press ev%0d: got cyc=%0d outs=%h, expected cyc=%0d outs=%h", i, o.cyc, o.outs, e.cyc, e.outs);
            else passed++;
        end
    endtask

    task automatic test_long_hold();
        int t, p, n;
        ev_t e, o;
        settle();
        drive(4'b1000, t);
        p = t + 1;
        push(p, 4'b1000, 4'd0, 4'd0, 4'd0);
        push(p + 500, 4'd0, 4'd0, 4'b1000, 4'd0);
        push(p + 501, 4'd0, 4'd0, 4'd0, 4'b1000);
`ifdef BUTTON_AUTO_REPEAT_EN
        push(p + 600, 4'b1000, 4'd0, 4'd0, 4'b1000);
        push(p + 700, 4'b1000, 4'd0, 4'd0, 4'b1000);
`endif
        idle(749);
        drive(4'd0, t);
        push(p + 750, 4'd0, 4'b1000, 4'd0, 4'd0);
        idle(5);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
            o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
            checks++;
            if (o !== e) $display("FAIL long_hold ev%0d: got cyc=%0d outs=%h, expected cyc=%0d outs=%h", i, o.cyc, o.outs, e.cyc, e.outs);
            else passed++;
        end
    endtask

    task automatic test_release_at_threshold();
        int t, p, n;
        ev_t e, o;
        settle();
        drive(4'b0001, t);
        p = t + 1;
        push(p, 4'b0001, 4'd0, 4'd0, 4'd0);
        idle(499);
        drive(4'd0, t);
        push(p + 500, 4'd0, 4'b0001, 4'd0, 4'd0);
        idle(5);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
            o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
            checks++;
            if (o !== e) $display("FAIL release_at_threshold ev%0d: got cyc=%0d outs=%h, expected cyc=%0d outs=%h", i, o.cyc, o.outs, e.cyc, e.outs);
            else passed++;
        end
    endtask

    task automatic test_code_change();
        int t, n;
        ev_t e, o;
        settle();
        drive(4'b0001, t);
        push(t + 1, 4'b0001, 4'd0, 4'd0, 4'd0);
        idle(19);
        drive(4'b0010, t);
        push(t + 1, 4'd0, 4'b0001, 4'd0, 4'd0);
        idle(30);
        drive(4'd0, t);
        idle(3);
        drive(4'b0010, t);
        push(t + 1, 4'b0010, 4'd0, 4'd0, 4'd0);
        idle(5);
        drive(4'd0, t);
        push(t + 1, 4'd0, 4'b0010, 4'd0, 4'd0);
        idle(5);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
            o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
            checks++;
            if (o !== e) $display("FAIL code_change ev%0d: got cyc=%0d outs=%h, expected cyc=%0d outs=%h", i, o.cyc, o.outs, e.cyc, e.outs);
            else passed++;
        end
    endtask

    task automatic test_non_onehot();
        int t, n;
        ev_t e, o;
        settle();
        drive(4'b0110, t);
        idle(20);
        drive(4'd0, t);
        idle(2);
        drive(4'b0001, t);
        push(t + 1, 4'b0001, 4'd0, 4'd0, 4'd0);
        idle(5);
        drive(4'd0, t);
        push(t + 1, 4'd0, 4'b0001, 4'd0, 4'd0);
        idle(5);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
            o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
            checks++;
            if (o !== e) $display("FAIL non_onehot ev%0d: got cyc=%0d outs=%h, expected cyc=%0d outs=%h", i, o.cyc, o.outs, e.cyc, e.outs);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int t, n;
        ev_t e, o;
        settle();
        drive(4'b0100, t);
        push(t + 1, 4'b0100, 4'd0, 4'd0, 4'd0);
        idle(4);
        drive(4'd0, t);
        push(t + 1, 4'd0, 4'b0100, 4'd0, 4'd0);
        drive(4'b1000, t);
        push(t + 1, 4'b1000, 4'd0, 4'd0, 4'd0);
        idle(4);
        drive(4'd0, t);
        push(t + 1, 4'd0, 4'b1000, 4'd0, 4'd0);
        idle(5);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
            o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
            checks++;
            if (o !== e) $display("FAIL back_to_back ev%0d: got cyc=%0d outs=%h, expected cyc=%0d outs=%h", i, o.cyc, o.outs, e.cyc, e.outs);
            else passed++;
        end
    endtask

    task automatic test_reset_midpress();
        int t, n;
        ev_t e, o;
        settle();
        drive(4'b0001, t);
        push(t + 1, 4'b0001, 4'd0, 4'd0, 4'd0);
        idle(300);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({pulse, rel, lng, held} !== 16'h0)
            $display("FAIL reset_midpress_outputs: got %h, expected 0000", {pulse, rel, lng, held});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        idle(600);
        drive(4'd0, t);
        idle(5);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
            o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
            checks++;
            if (o !== e) $display("FAIL reset_midpress ev%0d: got cyc=%0d outs=%h, expected cyc=%0d outs=%h", i, o.cyc, o.outs, e.cyc, e.outs);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_hold();
        test_release_at_threshold();
        test_code_change();
        test_non_onehot();
        test_back_to_back();
        test_reset_midpress();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
